// File: rtl/rv_enc_pkg.sv
// Shared types and opcodes for the RV64 instruction encoder/loader.
package rv_enc_pkg;

    typedef enum logic [1:0] {
        K_R   = 2'd0,
        K_LW  = 2'd1,
        K_SW  = 2'd2,
        K_BEQ = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: decoded fields + immediate -> 32-bit RV instruction.
module instr_packer
    import rv_enc_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic [31:0] word,
    output logic        imm_ok
);

    kind_t k;
    logic  fits12;
    logic  fits13;

    assign k = kind_t'(kind);

    // Sign-extension from bit 11 / bit 12 must reproduce the full 64-bit value.
    assign fits12 = (&imm[63:11]) | ~(|imm[63:11]);
    assign fits13 = (&imm[63:12]) | ~(|imm[63:12]);

    always_comb begin
        word   = 32'h0;
        imm_ok = 1'b0;
        unique case (k)
            K_R: begin
                word   = {funct7, rs2, rs1, funct3, rd, OP_R};
                imm_ok = 1'b1;
            end
            K_LW: begin
                word   = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                imm_ok = fits12;
            end
            K_SW: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                imm_ok = fits12;
            end
            K_BEQ: begin
                word   = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], OP_BRANCH};
                imm_ok = fits13 & ~imm[0];
            end
            default: begin
                word   = 32'h0;
                imm_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles and streams the words into instruction memory.
module instr_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [63:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t      state;
    logic [31:0] word;
    logic        imm_ok;

    instr_packer u_packer (
        .kind   (in_kind),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (word),
        .imm_ok (imm_ok)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= 32'h0;
            word_cnt   <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (imm_ok) begin
                            imem_wdata <= word;
                            imem_we    <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ready) begin
                        imem_we   <= 1'b0;
                        imem_addr <= imem_addr + ADDR_W'(4);
                        word_cnt  <= word_cnt + CNT_W'(1);
                        // The last slot fills the memory; no further bundles taken.
                        if (word_cnt == CNT_W'(DEPTH - 1)) begin
                            state <= FULL;
                            full  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FULL: begin
                    imem_we <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4).
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        full;
    logic        err;
    logic [2:0]  word_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_0000),
        .ADDR_W    (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .full       (full),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    // Present a bundle at a negedge, wait for the handshake edge, return at the next negedge.
    task automatic send(input logic [1:0] k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] imm);
        int n;
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_we, full, err, word_cnt, in_ready} !== {3'b000, 3'd0, 1'b1}
            || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: we=%b full=%b err=%b cnt=%0d rdy=%b addr=%h wdata=%h required 0 0 0 0 1 0 0",
                     imem_we, full, err, word_cnt, in_ready, imem_addr, imem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  k;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic test_encode();
        vec_t v[3];
        v[0] = '{2'd1, 5'd10, 5'd21, 5'd0, 3'd2, 64'h423, 32'h423AA503};
        v[1] = '{2'd2, 5'd0, 5'd21, 5'd3, 3'd2, 64'h431, 32'h423AA8A3};
        v[2] = '{2'd3, 5'd0, 5'd21, 5'd3, 3'd2, 64'hFFFF_FFFF_FFFF_F42E, 32'hC23AA763};
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(v[i].k, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, 7'h7F, v[i].imm);
            checks++;
            if (imem_we !== 1'b1 || imem_wdata !== v[i].exp
                || imem_addr !== 32'(i * 4) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL encode_%0d: we=%b wdata=%h addr=%h rdy=%b required 1 %h %h 0",
                         i, imem_we, imem_wdata, imem_addr, in_ready, v[i].exp, 32'(i * 4));
            end
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b0 || word_cnt !== 3'(i + 1)
                || imem_addr !== 32'(i * 4 + 4)) begin
                failures++;
                $display("FAIL accept_%0d: we=%b cnt=%0d addr=%h required 0 %0d %h",
                         i, imem_we, word_cnt, imem_addr, i + 1, 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_range_err();
        logic [1:0]  k[2];
        logic [63:0] imm[2];
        k[0] = 2'd1; imm[0] = 64'h800;
        k[1] = 2'd3; imm[1] = 64'h3;
        for (int i = 0; i < 2; i++) begin
            send(k[i], 5'd1, 5'd2, 5'd3, 3'd2, 7'd0, imm[i]);
            checks++;
            if (err !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL range_err_%0d: err=%b we=%b rdy=%b required 1 0 1",
                         i, err, imem_we, in_ready);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || imem_we !== 1'b0 || word_cnt !== 3'd3
                || imem_addr !== 32'hC) begin
                failures++;
                $display("FAIL range_after_%0d: err=%b we=%b cnt=%0d addr=%h required 0 0 3 0000000c",
                         i, err, imem_we, word_cnt, imem_addr);
            end
        end
    endtask

    task automatic test_stall_reset();
        imem_ready = 1'b0;
        send(2'd1, 5'd10, 5'd21, 5'd0, 3'd2, 7'd0, 64'h423);
        // A different bundle offered while busy must be ignored.
        in_kind = 2'd0; in_funct7 = 7'h20; in_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 32'hC
                || imem_wdata !== 32'h423AA503 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_%0d: we=%b addr=%h wdata=%h rdy=%b required 1 0000000c 423aa503 0",
                         c, imem_we, imem_addr, imem_wdata, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 32'h0 || word_cnt !== 3'd0
            || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_reset: we=%b addr=%h cnt=%0d rdy=%b required 0 0 0 1",
                     imem_we, imem_addr, word_cnt, in_ready);
        end
        imem_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full();
        int wrote;
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'hDEAD);
            checks++;
            if (imem_we !== 1'b1 || imem_wdata !== 32'h002081B3
                || imem_addr !== 32'(i * 4)) begin
                failures++;
                $display("FAIL rtype_%0d: we=%b wdata=%h addr=%h required 1 002081b3 %h",
                         i, imem_we, imem_wdata, imem_addr, 32'(i * 4));
            end
            @(negedge clk);
        end
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || word_cnt !== 3'd4) begin
            failures++;
            $display("FAIL full_state: full=%b rdy=%b cnt=%0d required 1 0 4",
                     full, in_ready, word_cnt);
        end
        in_valid = 1'b1;
        wrote = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_we !== 1'b0) wrote++;
        end
        in_valid = 1'b0;
        checks++;
        if (wrote != 0 || word_cnt !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_ignore: writes=%0d cnt=%0d full=%b required 0 4 1",
                     wrote, word_cnt, full);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; imem_ready = 1'b1;
        in_kind = 2'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 64'd0;
        @(negedge clk);
        test_reset();
        test_encode();
        test_range_err();
        test_stall_reset();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the immediate extractor: takes decoded instruction fields plus a 64-bit signed immediate and packs them into a 32-bit RV64 instruction word (R, I-load, S, B formats).
- Writes the encoded words sequentially into instruction memory over a ready/valid write port.
- Used by benches and boot logic to load programs that the processor fetches and sign-extends.

Parameters:
- DEPTH, 64, number of 32-bit words loadable before full.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- ADDR_W, 32, width of the memory byte address.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_kind  in  2  0=R (0110011), 1=LW (0000011), 2=SW (0100011), 3=BEQ (1100011)
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  64  signed immediate (byte offset for BEQ)
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded instruction
- full  out  1  DEPTH words written
- err  out  1  one-cycle pulse: immediate out of range, bundle dropped
- word_cnt  out  $clog2(DEPTH+1)  words written so far

Behaviour:
- Reset (synchronous, active-high): state IDLE; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_cnt=0, full=0, err=0. A reset asserted during WRITE abandons the pending write with no completion.
- FSM states: IDLE, WRITE, FULL.
- IDLE:
  - in_ready=1.
  - On in_valid, the bundle is range-checked and encoded combinationally, then registered.
  - Valid bundle: imem_wdata is loaded and the FSM moves to WRITE, so imem_we rises the next cycle (latency 1).
  - Invalid bundle: err pulses for 1 cycle, the FSM stays in IDLE, and word_cnt and address are unchanged.
- WRITE:
  - in_ready=0.
  - imem_we, imem_addr and imem_wdata are held stable until imem_ready=1.
  - On the accept cycle, word_cnt increments and imem_addr increases by 4 on the next edge.
  - The FSM then goes to FULL if word_cnt reaches DEPTH, otherwise to IDLE.
  - Throughput is at most one word per 2 cycles.
- FULL: full=1, in_ready=0, imem_we=0. Only reset leaves this state.
- Range rules:
  - LW and SW are legal only if in_imm[63:11] are all equal (range -2048..2047).
  - BEQ is legal only if in_imm[0]==0 and in_imm[63:12] are all equal.
  - R ignores in_imm.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - LW: {imm[11:0], rs1, funct3, rd, op}.
  - SW: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - Unused fields (rd for SW/BEQ, rs2 for LW) are ignored, never encoded.
- in_valid while in_ready=0 is ignored; the source holds its bundle until a handshake occurs.
- Address wrap is impossible: FULL is reached first.

Decomposition:
- Package rv_enc_pkg:
  - kind_t enum (R, LW, SW, BEQ).
  - Opcode constants OP_R, OP_LOAD, OP_STORE, OP_BRANCH.
  - state_t (IDLE, WRITE, FULL).
- Sub-module instr_packer: purely combinational. Inputs are the fields and kind; outputs are the 32-bit word and imm_ok. The top module holds the FSM, counters and write port.

Test Plan:
- LW, rs1=21, f3=2, rd=10, imm=64'h423 -> imem_wdata=32'h423AA503 at addr 0x0, imem_we one cycle after the handshake, word_cnt=1.
- SW, rs2=3, rs1=21, f3=2, imm=64'h431 -> 32'h423AA8A3 at addr 0x4.
- BEQ, rs2=3, rs1=21, f3=2, imm=64'hFFFF_FFFF_FFFF_F42E -> 32'hC23AA763 at addr 0x8.
- LW with imm=64'h800, then BEQ with imm=64'h3 -> err pulses once for each, no imem_we, word_cnt and address unchanged.
- Hold imem_ready=0 for 5 cycles during WRITE -> addr/wdata stable, in_ready=0. Assert reset in the 3rd stall cycle -> imem_we=0, addr=BASE_ADDR, word_cnt=0 next cycle.
- With DEPTH=4, write 4 R-type words (funct7=0, rs2=2, rs1=1, f3=0, rd=3 -> 32'h002081B3) -> full=1, in_ready=0, a further in_valid produces no write.
